// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes icache fetches and dcache reads/writes onto a single RAM port.
// Optional macro ARB_STARVE_GUARD_EN forces an instruction grant after STARVE_LIMIT data completions.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  state_t state;
  logic   dwrite;
  logic   dreq;
  logic   icomplete;
  logic   dcomplete;
  logic   istarved;

  assign dreq = dREN | dWEN;

  // A request dropped in the same cycle as ACCESS counts as an abort, not a completion.
  assign icomplete = (state == IGNT) && iREN && (ramstate == RAM_ACCESS);
  assign dcomplete = (state == DGNT) && dreq && (ramstate == RAM_ACCESS);

  assign iwait = ~icomplete;
  assign dwait = ~dcomplete;
  assign iload = icomplete ? ramload : '0;
  assign dload = (dcomplete && !dwrite) ? ramload : '0;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starvecnt;

  assign istarved = (32'(starvecnt) >= 32'(STARVE_LIMIT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      starvecnt <= '0;
    end else if (icomplete) begin
      starvecnt <= '0;
    end else if ((state == IDLE) && !iREN) begin
      starvecnt <= '0;
    end else if (dcomplete && iREN && (starvecnt != 3'd7)) begin
      starvecnt <= starvecnt + 3'd1;
    end
  end
`else
  // Strict data priority: the instruction side never pre-empts pending data.
  assign istarved = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      dwrite   <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iREN && (istarved || !dreq)) begin
            state   <= IGNT;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
            ramaddr <= iaddr;
          end else if (dreq) begin
            state    <= DGNT;
            dwrite   <= dWEN;
            ramREN   <= ~dWEN;
            ramWEN   <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dstore;
          end
        end
        IGNT: begin
          if (!iREN || (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR)) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end
        end
        DGNT: begin
          // ERROR releases the port; the still-pending request is re-arbitrated from IDLE.
          if (!dreq || (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR)) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

endmodule
